// File: rtl/adpcm_accum_seq.sv
// rtl/adpcm_accum_seq.sv - serial zero/pole accumulator for the ADPCM predictor
// One shared adder sums NZ zero terms then NP pole terms, one term per clock.
module adpcm_accum_seq #(
    parameter int WIDTH = 16,
    parameter int NZ    = 6,
    parameter int NP    = 2,
    parameter int SAT   = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [NZ*WIDTH-1:0] wb_flat,
    input  logic [NP*WIDTH-1:0] wa_flat,
    output logic                busy,
    output logic                sez_vld,
    output logic                done,
    output logic [WIDTH-2:0]    sez,
    output logic [WIDTH-2:0]    se,
    output logic                ovr
);
    localparam int N  = NZ + NP;
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] term_q [N];
    logic             busy_q, busy_d;
    logic             sez_vld_q, sez_vld_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-2:0] sez_q, sez_d;
    logic [WIDTH-2:0] se_q, se_d;
    logic             accept;
    logic [WIDTH-1:0] term, sum_raw, sum_f;
    logic             ovf;

    assign term    = term_q[idx_q];
    assign sum_raw = acc_q + term;
    // Signed overflow: operands agree in sign but the result does not.
    assign ovf     = (acc_q[WIDTH-1] == term[WIDTH-1]) && (sum_raw[WIDTH-1] != acc_q[WIDTH-1]);

    always_comb begin
        sum_f = sum_raw;
        if (SAT != 0 && ovf) begin
            sum_f = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        sez_vld_d = 1'b0;
        done_d    = 1'b0;
        ovr_d     = ovr_q;
        sez_d     = sez_q;
        se_d      = se_q;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) accept = 1'b1;
            end
            ACC: begin
                acc_d = sum_f;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(NZ - 1)) begin
                    sez_d     = sum_f[WIDTH-1:1];
                    sez_vld_d = 1'b1;
                end
                // The last-term cycle doubles as an idle slot so held start runs every N cycles.
                if (idx_q == IW'(N - 1)) begin
                    se_d    = sum_f[WIDTH-1:1];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = idx_q;
                    state_d = IDLE;
                    if (start) accept = 1'b1;
                end else if (start) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = ACC;
            acc_d   = '0;
            idx_d   = '0;
            busy_d  = 1'b1;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            sez_vld_q <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            sez_q     <= '0;
            se_q      <= '0;
            for (int i = 0; i < N; i++) term_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            sez_vld_q <= sez_vld_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            sez_q     <= sez_d;
            se_q      <= se_d;
            if (accept) begin
                for (int i = 0; i < NZ; i++) term_q[i] <= wb_flat[i*WIDTH +: WIDTH];
                for (int j = 0; j < NP; j++) term_q[NZ+j] <= wa_flat[j*WIDTH +: WIDTH];
            end
        end
    end

    assign busy    = busy_q;
    assign sez_vld = sez_vld_q;
    assign done    = done_q;
    assign ovr     = ovr_q;
    assign sez     = sez_q;
    assign se      = se_q;

endmodule
